// File: rtl/instr_fetch.sv
// Instruction fetch stage for the non-pipelined RV32I core: PC, imem handshake, IR latch.
// Redirects are taken only when the held instruction is consumed; a misaligned target locks the stage.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic [31:0] IR,
    output logic [31:0] pc_out,
    output logic [31:0] instr_count,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_pc_out, r_count;
    logic        r_fault;
    logic        w_handshake, w_misaligned;

    assign w_handshake  = (r_state == S_HOLD) && ir_ready;
    assign w_misaligned = pc_load && (pc_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (imem_rvalid) w_next = S_HOLD;
            S_HOLD:  if (ir_ready)    w_next = w_misaligned ? S_FAULT : S_FETCH;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_ir     <= NOP_INSTR;
            r_pc_out <= RESET_PC;
            r_count  <= 32'd0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == S_FETCH && imem_rvalid) begin
                r_ir     <= imem_rdata;
                r_pc_out <= r_pc;
            end
            if (w_handshake) begin
                r_count <= r_count + 32'd1;
                if (!pc_load)          r_pc <= r_pc + 32'd4;
                else if (!w_misaligned) r_pc <= pc_target;
                // Faulting redirect leaves the PC alone and scrubs IR on the same edge
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                    r_ir    <= NOP_INSTR;
                end
            end
            if (r_state == S_FAULT) r_ir <= NOP_INSTR;
        end
    end

    // Gated by rst_n so the request drops immediately on reset assertion
    assign imem_req    = rst_n && (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign ir_valid    = (r_state == S_HOLD);
    assign IR          = r_ir;
    assign pc_out      = r_pc_out;
    assign instr_count = r_count;
    assign fetch_fault = r_fault;

endmodule
